// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shifter with a valid/ready load handshake.
// A word accepted on `pdata` leaves on `so` one bit per enabled clock,
// framed by `frame` and `last`. Back-to-back words run with no idle gap.
module piso_shift_reg #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pdata,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             so,
  output logic             frame,
  output logic             last
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic             so_q,      so_d;
  logic             frame_q,   frame_d;
  logic             last_q,    last_d;

  logic             on_last_bit_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  // Move the word one position toward the serial output end.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      shift_one = {w[WIDTH-2:0], 1'b0};
    end else begin
      shift_one = {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Bit of a word that sits at the serial output end.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      out_bit = w[WIDTH-1];
    end else begin
      out_bit = w[0];
    end
  endfunction

  assign on_last_bit_s = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_LAST);
  // Ready in IDLE, or in the final bit period when that bit is about to
  // retire, so the next word can follow without a gap.
  assign load_ready    = !rst && ((state_q == ST_IDLE) || (on_last_bit_s && bit_en));
  assign accept_s      = load_valid && load_ready;
  assign shifted_s     = shift_one(shreg_q);

  // Next-state and next-output logic; holding is the default.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    so_d      = so_q;
    frame_d   = frame_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_SHIFT;
          shreg_d   = pdata;
          bit_cnt_d = CNT_ZERO;
          so_d      = out_bit(pdata);
          frame_d   = 1'b1;
          last_d    = 1'b0;
        end else begin
          so_d    = IDLE_LEVEL;
          frame_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!bit_en) begin
          // Stretch the current bit period; everything holds.
          state_d = ST_SHIFT;
        end else if (bit_cnt_q != CNT_LAST) begin
          shreg_d   = shifted_s;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          so_d      = out_bit(shifted_s);
          frame_d   = 1'b1;
          last_d    = (bit_cnt_q == CNT_PENULT);
        end else if (accept_s) begin
          // Gapless chaining: new word's first bit follows the old last bit.
          shreg_d   = pdata;
          bit_cnt_d = CNT_ZERO;
          so_d      = out_bit(pdata);
          frame_d   = 1'b1;
          last_d    = 1'b0;
        end else begin
          state_d   = ST_IDLE;
          bit_cnt_d = CNT_ZERO;
          so_d      = IDLE_LEVEL;
          frame_d   = 1'b0;
          last_d    = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = CNT_ZERO;
        shreg_d   = {WIDTH{1'b0}};
        so_d      = IDLE_LEVEL;
        frame_d   = 1'b0;
        last_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= CNT_ZERO;
      shreg_q   <= {WIDTH{1'b0}};
      so_q      <= IDLE_LEVEL;
      frame_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      so_q      <= so_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
    end
  end

  assign so    = so_q;
  assign frame = frame_q;
  assign last  = last_q;

endmodule
